// File: rtl/mem_access_unit_pkg.sv
// Shared bus widths, byte-select encodings and access classification helpers
// for the memory-stage load/store unit.
package mem_access_unit_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int SEL_W  = 4;

  localparam logic [SEL_W-1:0] SEL_BYTE = 4'b0001;
  localparam logic [SEL_W-1:0] SEL_HALF = 4'b0011;
  localparam logic [SEL_W-1:0] SEL_WORD = 4'b1111;

  // Only byte, half and word selects describe a real access.
  function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
    return (sel == SEL_BYTE) || (sel == SEL_HALF) || (sel == SEL_WORD);
  endfunction

  // Halves need an even address, words need a word-aligned address.
  function automatic logic is_misaligned(input logic [SEL_W-1:0] sel,
                                         input logic [1:0]       offset);
    return ((sel == SEL_HALF) && offset[0]) ||
           ((sel == SEL_WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane steering: store strobes / data replication on the way
// out, and load shift / sign- or zero-extension on the way back.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [SEL_W-1:0]  i_st_sel,
  input  logic [1:0]        i_st_offset,
  input  logic [DATA_W-1:0] i_st_data,
  output logic [SEL_W-1:0]  o_st_strobe,
  output logic [DATA_W-1:0] o_st_data,
  input  logic [SEL_W-1:0]  i_ld_sel,
  input  logic [1:0]        i_ld_offset,
  input  logic              i_ld_sign,
  input  logic [DATA_W-1:0] i_ld_raw,
  output logic [DATA_W-1:0] o_ld_data
);

  logic [DATA_W-1:0] w_ld_shifted;

  // Store side: strobes follow the select shifted into the addressed lane,
  // data is replicated so every possible lane carries the value.
  always_comb begin
    o_st_strobe = i_st_sel << i_st_offset;
    case (i_st_sel)
      SEL_BYTE: o_st_data = {4{i_st_data[7:0]}};
      SEL_HALF: o_st_data = {2{i_st_data[15:0]}};
      default:  o_st_data = i_st_data;
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then trim and extend.
  always_comb begin
    w_ld_shifted = i_ld_raw >> {i_ld_offset, 3'b000};
    case (i_ld_sel)
      SEL_BYTE: o_ld_data = i_ld_sign ? {{24{w_ld_shifted[7]}}, w_ld_shifted[7:0]}
                                      : {24'h000000, w_ld_shifted[7:0]};
      SEL_HALF: o_ld_data = i_ld_sign ? {{16{w_ld_shifted[15]}}, w_ld_shifted[15:0]}
                                      : {16'h0000, w_ld_shifted[15:0]};
      default:  o_ld_data = w_ld_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: single-outstanding request/ready handshake to
// data RAM, pipeline stall while in flight, misalignment flagging.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for an access; misaligned ones are flagged here
// REQ     | request on the RAM bus, held until ram_ready
// DONE    | transaction finished, load result presented for one cycle
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_flag,
  input  logic              mem_write_flag,
  input  logic              mem_sign_ext_flag,
  input  logic [SEL_W-1:0]  mem_sel,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              ram_en,
  output logic [SEL_W-1:0]  ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data,
  input  logic              ram_ready,
  output logic              stall_request,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              addr_err_load,
  output logic              addr_err_store
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic              w_access;
  logic              w_misaligned;
  logic              w_issue;

  logic [ADDR_W-1:0] r_ram_addr;
  logic [SEL_W-1:0]  r_ram_write_en;
  logic [DATA_W-1:0] r_ram_write_data;
  logic [DATA_W-1:0] r_load_data;
  logic              r_is_load;
  logic [SEL_W-1:0]  r_ld_sel;
  logic [1:0]        r_ld_offset;
  logic              r_ld_sign;

  logic [SEL_W-1:0]  w_st_strobe;
  logic [DATA_W-1:0] w_st_data;
  logic [DATA_W-1:0] w_ld_data;

  assign w_access     = (mem_read_flag | mem_write_flag) & sel_legal(mem_sel);
  assign w_misaligned = is_misaligned(mem_sel, mem_addr[1:0]);
  assign w_issue      = (r_state == ST_IDLE) & w_access & ~w_misaligned;

  mem_lane_align u_lane_align (
    .i_st_sel    (mem_sel),
    .i_st_offset (mem_addr[1:0]),
    .i_st_data   (mem_write_data),
    .o_st_strobe (w_st_strobe),
    .o_st_data   (w_st_data),
    .i_ld_sel    (r_ld_sel),
    .i_ld_offset (r_ld_offset),
    .i_ld_sign   (r_ld_sign),
    .i_ld_raw    (ram_read_data),
    .o_ld_data   (w_ld_data)
  );

  // State register; reset drops any in-flight request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; DONE never chains into a new request because the
  // stage inputs still describe the instruction that just completed.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_issue)   w_next_state = ST_REQ;
      ST_REQ:  if (ram_ready) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs; the IDLE terms are combinational from the stage inputs and are
  // masked during reset so an asserted rst silences the bus and the stall.
  always_comb begin
    ram_en         = 1'b0;
    stall_request  = 1'b0;
    load_valid     = 1'b0;
    addr_err_load  = 1'b0;
    addr_err_store = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!rst) begin
          stall_request  = w_issue;
          addr_err_store = w_access & mem_write_flag & w_misaligned;
          addr_err_load  = w_access & mem_read_flag & ~mem_write_flag & w_misaligned;
        end
      end
      ST_REQ: begin
        ram_en        = 1'b1;
        stall_request = 1'b1;
      end
      ST_DONE: load_valid = r_is_load;
      default: ;
    endcase
  end

  // Bus registers load on issue and hold through REQ; the load result is
  // captured on the completing ready and held until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram_addr       <= '0;
      r_ram_write_en   <= '0;
      r_ram_write_data <= '0;
      r_load_data      <= '0;
      r_is_load        <= 1'b0;
      r_ld_sel         <= '0;
      r_ld_offset      <= 2'b00;
      r_ld_sign        <= 1'b0;
    end else begin
      if (w_issue) begin
        r_ram_addr       <= {mem_addr[ADDR_W-1:2], 2'b00};
        r_ram_write_en   <= mem_write_flag ? w_st_strobe : '0;
        r_ram_write_data <= w_st_data;
        r_is_load        <= ~mem_write_flag;
        r_ld_sel         <= mem_sel;
        r_ld_offset      <= mem_addr[1:0];
        r_ld_sign        <= mem_sign_ext_flag;
      end
      if ((r_state == ST_REQ) && ram_ready && r_is_load) begin
        r_load_data <= w_ld_data;
      end
    end
  end

  assign ram_addr       = r_ram_addr;
  assign ram_write_en   = r_ram_write_en;
  assign ram_write_data = r_ram_write_data;
  assign load_data      = r_load_data;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        mem_read_flag;
  logic        mem_write_flag;
  logic        mem_sign_ext_flag;
  logic [3:0]  mem_sel;
  logic [31:0] mem_write_data;
  logic [31:0] mem_addr;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        ram_ready;
  logic        stall_request;
  logic [31:0] load_data;
  logic        load_valid;
  logic        addr_err_load;
  logic        addr_err_store;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        is_load;
    logic [31:0] ldata;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_load;

  mem_access_unit dut (
    .clk               (clk),
    .rst               (rst),
    .mem_read_flag     (mem_read_flag),
    .mem_write_flag    (mem_write_flag),
    .mem_sign_ext_flag (mem_sign_ext_flag),
    .mem_sel           (mem_sel),
    .mem_write_data    (mem_write_data),
    .mem_addr          (mem_addr),
    .ram_en            (ram_en),
    .ram_write_en      (ram_write_en),
    .ram_addr          (ram_addr),
    .ram_write_data    (ram_write_data),
    .ram_read_data     (ram_read_data),
    .ram_ready         (ram_ready),
    .stall_request     (stall_request),
    .load_data         (load_data),
    .load_valid        (load_valid),
    .addr_err_load     (addr_err_load),
    .addr_err_store    (addr_err_store)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference load extraction written per byte lane.
  function automatic logic [31:0] model_load(input logic [31:0] raw, input logic [3:0] sel,
                                             input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = raw[8*off +: 8];
    h = (off == 2'd2) ? raw[31:16] : raw[15:0];
    if (sel == 4'b0001) return sgn ? {{24{b[7]}}, b} : {24'd0, b};
    if (sel == 4'b0011) return sgn ? {{16{h[15]}}, h} : {16'd0, h};
    return raw;
  endfunction

  function automatic logic [3:0] model_strobe(input logic [3:0] sel, input logic [1:0] off);
    if (sel == 4'b1111) return 4'b1111;
    if (sel == 4'b0011) return (off == 2'd2) ? 4'b1100 : 4'b0011;
    case (off)
      2'd0: return 4'b0001;
      2'd1: return 4'b0010;
      2'd2: return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic clear_inputs();
    mem_read_flag     = 1'b0;
    mem_write_flag    = 1'b0;
    mem_sign_ext_flag = 1'b0;
    mem_sel           = 4'b0000;
    mem_write_data    = 32'd0;
    mem_addr          = 32'd0;
    ram_ready         = 1'b0;
  endtask

  // Drives one aligned access through a responsive RAM that asserts ready
  // after wait_n REQ cycles, checking the bus against the scoreboard head.
  task automatic do_access(input logic rd, input logic wr, input logic sgn,
                           input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int wait_n, input logic [3:0] exp_we,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_ld);
    exp_t e;
    int   stall_cnt, req_cnt, lv_cnt;
    bit   done;
    @(negedge clk);
    mem_read_flag     = rd;
    mem_write_flag    = wr;
    mem_sign_ext_flag = sgn;
    mem_sel           = sel;
    mem_addr          = addr;
    mem_write_data    = wdata;
    ram_read_data     = rdata;
    ram_ready         = 1'b0;
    e.addr    = {addr[31:2], 2'b00};
    e.we      = wr ? exp_we : 4'b0000;
    e.wdata   = exp_wdata;
    e.is_load = ~wr;
    e.ldata   = exp_ld;
    sb_q.push_back(e);
    stall_cnt = 0; req_cnt = 0; lv_cnt = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (stall_request) stall_cnt++;
      if (load_valid) lv_cnt++;
      if (ram_en) begin
        req_cnt++;
        checks++;
        if (ram_addr !== sb_q[0].addr || ram_write_en !== sb_q[0].we ||
            ram_write_data !== sb_q[0].wdata) begin
          errors++;
          $display("FAIL req_bus cyc%0d: got addr=%h we=%b wd=%h want addr=%h we=%b wd=%h",
                   req_cnt, ram_addr, ram_write_en, ram_write_data,
                   sb_q[0].addr, sb_q[0].we, sb_q[0].wdata);
        end
        ram_ready = (req_cnt > wait_n);
      end else if (c > 0 && !stall_request) begin
        done = 1;
      end
      if (!done) @(negedge clk);
    end
    clear_inputs();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: access at %h never reached DONE", addr);
    end else begin
      e = sb_q.pop_front();
      if (e.is_load) last_load = e.ldata;
      if (load_data !== last_load) begin
        errors++;
        $display("FAIL load_data: got %h want %h", load_data, last_load);
      end
      checks++;
      if (stall_cnt !== 2 + wait_n) begin
        errors++;
        $display("FAIL stall_cycles: got %0d want %0d", stall_cnt, 2 + wait_n);
      end
      checks++;
      if (req_cnt !== 1 + wait_n) begin
        errors++;
        $display("FAIL req_cycles: got %0d want %0d", req_cnt, 1 + wait_n);
      end
      checks++;
      if (lv_cnt !== (e.is_load ? 1 : 0)) begin
        errors++;
        $display("FAIL load_valid_count: got %0d want %0d", lv_cnt, e.is_load ? 1 : 0);
      end
      @(negedge clk);
      #1;
      checks++;
      if (load_valid !== 1'b0 || ram_en !== 1'b0 || stall_request !== 1'b0) begin
        errors++;
        $display("FAIL post_done: got lv=%b en=%b stall=%b want 0 0 0",
                 load_valid, ram_en, stall_request);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    ram_read_data = 32'd0;
    last_load = 32'd0;
    @(negedge clk);
    #1;
    checks++;
    if (ram_en !== 1'b0 || ram_write_en !== 4'b0000 || ram_addr !== 32'd0 ||
        ram_write_data !== 32'd0 || load_data !== 32'd0 || load_valid !== 1'b0 ||
        stall_request !== 1'b0 || addr_err_load !== 1'b0 || addr_err_store !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got en=%b we=%b a=%h wd=%h ld=%h lv=%b st=%b want all zero",
               ram_en, ram_write_en, ram_addr, ram_write_data, load_data, load_valid,
               stall_request);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stores();
    do_access(1'b0, 1'b1, 1'b0, 4'b1111, 32'h100, 32'hDEADBEEF, 32'd0, 0,
              4'b1111, 32'hDEADBEEF, 32'd0);
    do_access(1'b0, 1'b1, 1'b0, 4'b0001, 32'h103, 32'h000000A5, 32'd0, 0,
              4'b1000, 32'hA5A5A5A5, 32'd0);
    // Both flags set: the store wins.
    do_access(1'b1, 1'b1, 1'b1, 4'b0011, 32'h2, 32'h00001234, 32'hFFFFFFFF, 1,
              4'b1100, 32'h12341234, 32'd0);
  endtask

  task automatic test_loads();
    do_access(1'b1, 1'b0, 1'b1, 4'b0001, 32'h102, 32'd0, 32'h12F03456, 0,
              4'b0000, 32'd0, 32'hFFFFFFF0);
    do_access(1'b1, 1'b0, 1'b0, 4'b0001, 32'h102, 32'd0, 32'h12F03456, 0,
              4'b0000, 32'd0, 32'h000000F0);
    do_access(1'b1, 1'b0, 1'b0, 4'b0011, 32'h102, 32'd0, 32'h12F03456, 0,
              4'b0000, 32'd0, 32'h000012F0);
    do_access(1'b1, 1'b0, 1'b1, 4'b0011, 32'h100, 32'd0, 32'h12F08456, 0,
              4'b0000, 32'd0, 32'hFFFF8456);
  endtask

  task automatic test_lw_wait();
    do_access(1'b1, 1'b0, 1'b1, 4'b1111, 32'h340, 32'd0, 32'h89ABCDEF, 4,
              4'b0000, 32'd0, 32'h89ABCDEF);
  endtask

  task automatic test_misaligned();
    logic [3:0]  sels [3] = '{4'b0011, 4'b1111, 4'b1111};
    logic [31:0] addrs[3] = '{32'h101, 32'h102, 32'h203};
    logic        wrs  [3] = '{1'b0, 1'b1, 1'b1};
    logic        rds  [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_read_flag  = rds[i];
      mem_write_flag = wrs[i];
      mem_sel        = sels[i];
      mem_addr       = addrs[i];
      mem_write_data = 32'h55AA55AA;
      #1;
      checks++;
      if (addr_err_load !== !wrs[i] || addr_err_store !== wrs[i] ||
          stall_request !== 1'b0 || ram_en !== 1'b0) begin
        errors++;
        $display("FAIL misalign_%0d: got el=%b es=%b st=%b en=%b want el=%b es=%b st=0 en=0",
                 i, addr_err_load, addr_err_store, stall_request, ram_en, !wrs[i], wrs[i]);
      end
      @(negedge clk);
      clear_inputs();
      #1;
      checks++;
      if (addr_err_load !== 1'b0 || addr_err_store !== 1'b0 || ram_en !== 1'b0 ||
          stall_request !== 1'b0) begin
        errors++;
        $display("FAIL misalign_after_%0d: got el=%b es=%b en=%b st=%b want 0",
                 i, addr_err_load, addr_err_store, ram_en, stall_request);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_read_flag  = 1'b1;
    mem_sel        = 4'b1111;
    mem_addr       = 32'h200;
    ram_ready      = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (ram_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_req: got ram_en=%b want 1", ram_en);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ram_en !== 1'b0 || stall_request !== 1'b0 || load_data !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: got en=%b stall=%b ld=%h want 0 0 0",
               ram_en, stall_request, load_data);
    end
    last_load = 32'd0;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    do_access(1'b1, 1'b0, 1'b0, 4'b1111, 32'h204, 32'd0, 32'hCAFEBABE, 0,
              4'b0000, 32'd0, 32'hCAFEBABE);
  endtask

  task automatic test_back_to_back();
    logic [3:0]  sel;
    logic [1:0]  off;
    logic        wr, sgn;
    logic [31:0] a, wd, rd_word, exp_wd;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0:       sel = 4'b0001;
        1:       sel = 4'b0011;
        default: sel = 4'b1111;
      endcase
      off = (sel == 4'b0001) ? 2'($urandom_range(0, 3)) :
            (sel == 4'b0011) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      a       = {$urandom_range(0, 16'hFFFF), 2'b00} | {30'd0, off};
      wr      = 1'($urandom_range(0, 1));
      sgn     = 1'($urandom_range(0, 1));
      wd      = $urandom;
      rd_word = $urandom;
      exp_wd  = (sel == 4'b0001) ? {wd[7:0], wd[7:0], wd[7:0], wd[7:0]} :
                (sel == 4'b0011) ? {wd[15:0], wd[15:0]} : wd;
      do_access(~wr, wr, sgn, sel, a, wd, rd_word, $urandom_range(0, 2),
                model_strobe(sel, off), exp_wd, model_load(rd_word, sel, off, sgn));
    end
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_lw_wait();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
